eth_frame_tx: RTL and testbench

Parametrised 10BASE-T frame serializer for the Ethernet transmit path. It holds one frame in a host-writable byte buffer and, on request, emits preamble, SFD, payload and an optional CRC-32 FCS as a serial bit stream advanced by the bit-rate strobe `enable`. The stream ends with a TP_IDL interval, and the block feeds the Manchester encoder and line driver.

---
 rtl/eth_frame_tx.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_eth_frame_tx.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_frame_tx.sv
// eth_frame_tx: 10BASE-T frame serializer for the Ethernet transmit path.
// Holds one frame in a host-writable byte buffer and, on request, emits
// preamble, SFD, payload and (optionally) a CRC-32 FCS, LSB first, one bit
// per `enable` strobe, followed by a TP_IDL interval.
// Optional feature: define ETH_FRAME_TX_CRC_EN to append the CRC-32 FCS.
module eth_frame_tx #(
    parameter int MAX_LEN      = 128,
    parameter int PREAMBLE_LEN = 7,
    parameter int IDLE_BITS    = 3,
    parameter int AW           = $clog2(MAX_LEN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW:0]   frame_len,
    input  logic          transmit,
    output logic          busy,
    output logic          tx_data,
    output logic          tx_en,
    output logic          tx_idle,
    output logic          done
);

    localparam int IW = (IDLE_BITS > 1) ? $clog2(IDLE_BITS) : 1;

    localparam logic [7:0]    PRE_BYTE  = 8'h55;
    localparam logic [7:0]    SFD_BYTE  = 8'hD5;
    localparam logic [AW:0]   CNT_ZERO  = {(AW + 1){1'b0}};
    localparam logic [AW:0]   CNT_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   MAX_LEN_W = (AW + 1)'(MAX_LEN);
    localparam logic [AW:0]   PRE_LAST  = (AW + 1)'(PREAMBLE_LEN - 1);
    localparam logic [IW-1:0] IDLE_ZERO = {IW{1'b0}};
    localparam logic [IW-1:0] IDLE_ONE  = {{(IW - 1){1'b0}}, 1'b1};
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_BITS - 1);
    localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREAMBLE = 3'd1,
        SFD      = 3'd2,
        PAYLOAD  = 3'd3,
        TP_IDL   = 3'd4
`ifdef ETH_FRAME_TX_CRC_EN
        ,
        FCS      = 3'd5
`endif
    } state_t;

`ifdef ETH_FRAME_TX_CRC_EN
    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

    // One bit of the reflected CRC-32 shift register.
    function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic bit_in);
        logic fb;
        fb = crc[0] ^ bit_in;
        crc_step = {1'b0, crc[31:1]} ^ (fb ? CRC_POLY : 32'h0000_0000);
    endfunction

    logic [31:0] crc_r;
    logic [31:0] crc_s;
    logic [31:0] crc_next_s;
`endif

    logic [7:0]    mem_r [MAX_LEN];
    state_t        state_r, state_s;
    logic [2:0]    bit_r, bit_s;
    logic [AW:0]   byte_r, byte_s;
    logic [IW-1:0] idle_r, idle_s;
    logic          pend_r, pend_s;
    logic [AW:0]   len_r, len_s;
    logic          busy_r, busy_s;
    logic          done_r, done_s;
    logic          tx_data_r, tx_data_s;
    logic          tx_en_r, tx_en_s;
    logic          tx_idle_r, tx_idle_s;
    logic [7:0]    pay_r, pay_s;

    logic          accept_s;
    logic          wr_ok_s;
    logic [2:0]    bit_inc_s;
    logic [AW:0]   byte_inc_s;
    logic [7:0]    next_byte_s;
    logic [7:0]    first_byte_s;

    // A request is taken only when fully idle; the `done` cycle is excluded.
    assign accept_s     = transmit && !busy_r && !done_r
                          && (frame_len != CNT_ZERO) && (frame_len <= MAX_LEN_W);
    assign wr_ok_s      = wr_en && !busy_r && ({1'b0, wr_addr} < MAX_LEN_W);
    assign bit_inc_s    = bit_r + 3'd1;
    assign byte_inc_s   = byte_r + CNT_ONE;
    assign next_byte_s  = mem_r[byte_inc_s[AW-1:0]];
    assign first_byte_s = mem_r[ADDR_ZERO];
`ifdef ETH_FRAME_TX_CRC_EN
    assign crc_next_s   = crc_step(crc_r, tx_data_r);
`endif

    // Frame buffer: host writes while not busy, never cleared by reset.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[wr_addr[AW-1:0]] <= wr_data;
        end
    end

    // Next-state, counter and output computation; advances only on `enable`.
    always_comb begin
        state_s   = state_r;
        bit_s     = bit_r;
        byte_s    = byte_r;
        idle_s    = idle_r;
        pend_s    = pend_r;
        len_s     = len_r;
        busy_s    = busy_r;
        done_s    = 1'b0;
        tx_data_s = tx_data_r;
        tx_en_s   = tx_en_r;
        tx_idle_s = tx_idle_r;
        pay_s     = pay_r;
`ifdef ETH_FRAME_TX_CRC_EN
        crc_s     = crc_r;
`endif

        if (accept_s) begin
            pend_s = 1'b1;
            len_s  = frame_len;
            busy_s = 1'b1;
        end else begin
            len_s  = len_r;
        end

        if (enable) begin
            case (state_r)
                IDLE: begin
                    if (pend_r) begin
                        state_s   = PREAMBLE;
                        pend_s    = 1'b0;
                        bit_s     = 3'd0;
                        byte_s    = CNT_ZERO;
                        tx_en_s   = 1'b1;
                        tx_data_s = PRE_BYTE[0];
                    end else begin
                        state_s   = IDLE;
                    end
                end
                PREAMBLE: begin
                    if (bit_r != 3'd7) begin
                        bit_s     = bit_inc_s;
                        tx_data_s = PRE_BYTE[bit_inc_s];
                    end else if (byte_r == PRE_LAST) begin
                        state_s   = SFD;
                        bit_s     = 3'd0;
                        byte_s    = CNT_ZERO;
                        tx_data_s = SFD_BYTE[0];
                    end else begin
                        bit_s     = 3'd0;
                        byte_s    = byte_inc_s;
                        tx_data_s = PRE_BYTE[0];
                    end
                end
                SFD: begin
                    if (bit_r != 3'd7) begin
                        bit_s     = bit_inc_s;
                        tx_data_s = SFD_BYTE[bit_inc_s];
                    end else begin
                        state_s   = PAYLOAD;
                        bit_s     = 3'd0;
                        byte_s    = CNT_ZERO;
                        pay_s     = first_byte_s;
                        tx_data_s = first_byte_s[0];
`ifdef ETH_FRAME_TX_CRC_EN
                        crc_s     = CRC_INIT;
`endif
                    end
                end
                PAYLOAD: begin
`ifdef ETH_FRAME_TX_CRC_EN
                    crc_s = crc_next_s;
`endif
                    if (bit_r != 3'd7) begin
                        bit_s     = bit_inc_s;
                        tx_data_s = pay_r[bit_inc_s];
                    end else if (byte_r == (len_r - CNT_ONE)) begin
                        bit_s     = 3'd0;
                        byte_s    = CNT_ZERO;
`ifdef ETH_FRAME_TX_CRC_EN
                        state_s   = FCS;
                        tx_data_s = ~crc_next_s[0];
`else
                        state_s   = TP_IDL;
                        idle_s    = IDLE_ZERO;
                        tx_en_s   = 1'b0;
                        tx_data_s = 1'b0;
                        tx_idle_s = 1'b1;
`endif
                    end else begin
                        bit_s     = 3'd0;
                        byte_s    = byte_inc_s;
                        pay_s     = next_byte_s;
                        tx_data_s = next_byte_s[0];
                    end
                end
`ifdef ETH_FRAME_TX_CRC_EN
                FCS: begin
                    if (bit_r != 3'd7) begin
                        bit_s     = bit_inc_s;
                        tx_data_s = ~crc_r[{byte_r[1:0], bit_inc_s}];
                    end else if (byte_r[1:0] == 2'd3) begin
                        state_s   = TP_IDL;
                        bit_s     = 3'd0;
                        byte_s    = CNT_ZERO;
                        idle_s    = IDLE_ZERO;
                        tx_en_s   = 1'b0;
                        tx_data_s = 1'b0;
                        tx_idle_s = 1'b1;
                    end else begin
                        bit_s     = 3'd0;
                        byte_s    = byte_inc_s;
                        tx_data_s = ~crc_r[{byte_inc_s[1:0], 3'd0}];
                    end
                end
`endif
                TP_IDL: begin
                    if (idle_r == IDLE_LAST) begin
                        state_s   = IDLE;
                        idle_s    = IDLE_ZERO;
                        tx_idle_s = 1'b0;
                        done_s    = 1'b1;
                        busy_s    = 1'b0;
                    end else begin
                        idle_s    = idle_r + IDLE_ONE;
                    end
                end
                default: begin
                    state_s   = IDLE;
                    bit_s     = 3'd0;
                    byte_s    = CNT_ZERO;
                    idle_s    = IDLE_ZERO;
                    pend_s    = 1'b0;
                    busy_s    = 1'b0;
                    tx_en_s   = 1'b0;
                    tx_data_s = 1'b0;
                    tx_idle_s = 1'b0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State, counters and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            bit_r     <= 3'd0;
            byte_r    <= CNT_ZERO;
            idle_r    <= IDLE_ZERO;
            pend_r    <= 1'b0;
            len_r     <= CNT_ZERO;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            tx_data_r <= 1'b0;
            tx_en_r   <= 1'b0;
            tx_idle_r <= 1'b0;
            pay_r     <= 8'h00;
`ifdef ETH_FRAME_TX_CRC_EN
            crc_r     <= 32'h0000_0000;
`endif
        end else begin
            state_r   <= state_s;
            bit_r     <= bit_s;
            byte_r    <= byte_s;
            idle_r    <= idle_s;
            pend_r    <= pend_s;
            len_r     <= len_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            tx_data_r <= tx_data_s;
            tx_en_r   <= tx_en_s;
            tx_idle_r <= tx_idle_s;
            pay_r     <= pay_s;
`ifdef ETH_FRAME_TX_CRC_EN
            crc_r     <= crc_s;
`endif
        end
    end

    assign busy    = busy_r;
    assign tx_data = tx_data_r;
    assign tx_en   = tx_en_r;
    assign tx_idle = tx_idle_r;
    assign done    = done_r;

endmodule

// File: tb/tb_eth_frame_tx.sv
// Scoreboard bench for eth_frame_tx: expected wire bits are queued when a
// frame is requested and popped by a monitor on every enable edge with tx_en.
module tb_eth_frame_tx;

    localparam int MAX_LEN   = 128;
    localparam int PRE_LEN   = 7;
    localparam int IDLE_BITS = 3;
    localparam int AW        = 7;
`ifdef ETH_FRAME_TX_CRC_EN
    localparam bit HAS_FCS = 1'b1;
`else
    localparam bit HAS_FCS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [7:0]    wr_data = 8'h00;
    logic [AW:0]   frame_len = '0;
    logic          transmit = 1'b0;
    logic          busy, tx_data, tx_en, tx_idle, done;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] img [MAX_LEN];
    logic       exp_q [$];
    int         en_period = 1;
    bit         mon_on = 1'b1;
    int         en_cyc, en_rise, idle_cyc, idle_bad, done_cnt;
    logic       tx_en_d = 1'b0;

    eth_frame_tx #(.MAX_LEN(MAX_LEN), .PREAMBLE_LEN(PRE_LEN), .IDLE_BITS(IDLE_BITS)) dut (
        .clk(clk), .rst(rst), .enable(enable), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .frame_len(frame_len), .transmit(transmit), .busy(busy),
        .tx_data(tx_data), .tx_en(tx_en), .tx_idle(tx_idle), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_crc(input int len);
        logic [31:0] c;
        logic [7:0]  v;
        logic        fb;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < len; i++) begin
            v = img[i];
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ v[b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return ~c;
    endfunction

    task automatic push_byte(input logic [7:0] v);
        for (int b = 0; b < 8; b++) exp_q.push_back(v[b]);
    endtask

    // Queue the full expected wire sequence of one frame; returns bit count.
    task automatic push_frame(input int len, input bit use_const, output int nbits);
        logic [31:0] f;
        for (int i = 0; i < PRE_LEN; i++) push_byte(8'h55);
        push_byte(8'hD5);
        for (int i = 0; i < len; i++) push_byte(img[i]);
        nbits = 8 * (PRE_LEN + 1 + len);
        if (HAS_FCS) begin
            if (use_const) begin
                push_byte(8'h26); push_byte(8'h39); push_byte(8'hF4); push_byte(8'hCB);
            end else begin
                f = ref_crc(len);
                for (int b = 0; b < 32; b++) exp_q.push_back(f[b]);
            end
            nbits = nbits + 32;
        end
    endtask

    // Bit-rate strobe: one clk wide, every en_period clocks.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (cnt >= en_period - 1) begin
                enable = 1'b1;
                cnt = 0;
            end else begin
                enable = 1'b0;
                cnt++;
            end
        end
    end

    // Monitor: scoreboard pops on enable edges, plus per-cycle statistics.
    initial begin
        logic e;
        logic exp_bit;
        forever begin
            @(posedge clk);
            e = enable;
            #1;
            if (tx_en === 1'b1) en_cyc++;
            if (tx_en === 1'b1 && tx_en_d === 1'b0) en_rise++;
            tx_en_d = tx_en;
            if (tx_idle === 1'b1) idle_cyc++;
            if (tx_idle === 1'b1 && (tx_en !== 1'b0 || tx_data !== 1'b0)) idle_bad++;
            if (done === 1'b1) done_cnt++;
            if (e && tx_en === 1'b1 && mon_on) begin
                check_val("q_has_bit", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    exp_bit = exp_q.pop_front();
                    check_val("wire_bit", tx_data, exp_bit);
                end
            end
        end
    end

    task automatic buf_write(input int addr, input logic [7:0] data);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = addr[AW-1:0]; wr_data = data;
        @(negedge clk);
        wr_en = 1'b0;
        img[addr] = data;
    endtask

    task automatic clear_stats();
        en_cyc = 0; en_rise = 0; idle_cyc = 0; idle_bad = 0; done_cnt = 0;
    endtask

    // Request one frame and check it end to end. retrig pulses transmit
    // mid-frame and in the done cycle; mid_wr writes buffer[0] while busy.
    task automatic send_frame(input int len, input int period, input bit use_const,
                              input bit retrig, input bit mid_wr);
        int nbits, budget;
        bit got_done;
        en_period = period;
        repeat (2 * period + 2) @(negedge clk);
        clear_stats();
        push_frame(len, use_const, nbits);
        frame_len = len[AW:0];
        transmit = 1'b1;
        @(negedge clk);
        transmit = 1'b0;
        check_val("busy_rise", busy, 1);
        budget = (nbits + IDLE_BITS + 4) * period + 50;
        got_done = 1'b0;
        for (int c = 0; c < budget && !got_done; c++) begin
            @(negedge clk);
            if (retrig && c == 20) transmit = 1'b1;
            if (retrig && c == 21) transmit = 1'b0;
            if (mid_wr && c == 400) begin
                wr_en = 1'b1; wr_addr = '0; wr_data = 8'h3C;
            end
            if (mid_wr && c == 401) wr_en = 1'b0;
            if (done === 1'b1) got_done = 1'b1;
        end
        check_val("done_seen", got_done, 1);
        if (retrig) transmit = 1'b1;
        @(negedge clk);
        transmit = 1'b0;
        check_val("busy_after_done", busy, 0);
        repeat (30) @(negedge clk);
        check_val("en_cycles", en_cyc, nbits * period);
        check_val("en_rises", en_rise, 1);
        check_val("idle_cycles", idle_cyc, IDLE_BITS * period);
        check_val("idle_clean", idle_bad, 0);
        check_val("done_pulses", done_cnt, 1);
        check_val("q_empty", exp_q.size(), 0);
        check_val("busy_quiet", busy, 0);
        exp_q.delete();
    endtask

    task automatic try_bad(input int len);
        @(negedge clk);
        frame_len = len[AW:0];
        transmit = 1'b1;
        @(negedge clk);
        transmit = 1'b0;
        check_val("bad_len_busy_now", busy, 0);
        repeat (10) @(negedge clk);
        check_val("bad_len_busy", busy, 0);
        check_val("bad_len_tx_en", tx_en, 0);
    endtask

    initial begin
        int nb;
        for (int i = 0; i < MAX_LEN; i++) img[i] = 8'h00;
        repeat (3) @(negedge clk);
        check_val("rst_busy", busy, 0);
        check_val("rst_tx_en", tx_en, 0);
        check_val("rst_tx_data", tx_data, 0);
        check_val("rst_tx_idle", tx_idle, 0);
        check_val("rst_done", done, 0);
        rst = 1'b0;

        // Single-byte frame, continuous enable.
        buf_write(0, 8'hA5);
        send_frame(1, 1, 1'b0, 1'b0, 1'b0);

        // Out-of-range lengths are ignored.
        try_bad(0);
        try_bad(129);

        // "123456789" check frame.
        for (int i = 0; i < 9; i++) buf_write(i, 8'h31 + i[7:0]);
        send_frame(9, 1, 1'b1, 1'b0, 1'b0);

        // Full-length frame, slow strobe, retriggers and a write while busy.
        for (int i = 0; i < MAX_LEN; i++) buf_write(i, 8'($urandom_range(0, 255)));
        send_frame(MAX_LEN, 5, 1'b0, 1'b1, 1'b1);

        // The same write after done lands in the next frame.
        buf_write(0, 8'h3C);
        send_frame(2, 1, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of the payload, then a clean frame.
        en_period = 1;
        for (int i = 0; i < 16; i++) buf_write(i, 8'(i * 17 + 3));
        clear_stats();
        push_frame(16, 1'b0, nb);
        frame_len = 8'd16;
        transmit = 1'b1;
        @(negedge clk);
        transmit = 1'b0;
        repeat (80) @(negedge clk);
        check_val("mid_tx_en", tx_en, 1);
        mon_on = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_val("mrst_busy", busy, 0);
        check_val("mrst_tx_en", tx_en, 0);
        check_val("mrst_tx_data", tx_data, 0);
        check_val("mrst_tx_idle", tx_idle, 0);
        check_val("mrst_done", done, 0);
        rst = 1'b0;
        exp_q.delete();
        repeat (10) @(negedge clk);
        check_val("mrst_stays_idle", tx_en, 0);
        mon_on = 1'b1;
        send_frame(16, 2, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
